// File: rtl/sdram_cmd_responder_if.sv
// SDRAM command bus between controller (master) and device model (slave).
// Carries strobes, address/bank, dq in/out, error flag and refresh count.
interface sdram_cmd_responder_if #(
  parameter int DATA_WIDTH = 16
);
  logic [12:0]           addr;
  logic [1:0]            ba;
  logic                  ras_n;
  logic                  cas_n;
  logic                  we_n;
  logic [DATA_WIDTH-1:0] dq_in;
  logic [DATA_WIDTH-1:0] dq_out;
  logic                  dq_oe;
  logic                  cmd_err;
  logic [15:0]           refresh_count;

  modport master (
    output addr, ba, ras_n, cas_n, we_n, dq_in,
    input  dq_out, dq_oe, cmd_err, refresh_count
  );

  modport slave (
    input  addr, ba, ras_n, cas_n, we_n, dq_in,
    output dq_out, dq_oe, cmd_err, refresh_count
  );
endinterface

// File: rtl/sdram_cmd_responder.sv
// SDRAM device-side responder: bank/mode tracking, CL-delayed bursts, checks.
// Ports: clk, rst (sync, active-high), bus (slave side of the command bus).
module sdram_cmd_responder #(
  parameter int MEM_ADDR_WIDTH = 12,
  parameter int DATA_WIDTH     = 16
) (
  input logic clk,
  input logic rst,
  sdram_cmd_responder_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR} st_t;

  st_t st, st_nxt;

  logic [3:0]  open_q, ap_q, ap_nxt;
  logic [12:0] row_q [4];
  logic        cl3_q;
  logic [3:0]  bl_q;
  logic [1:0]  b_bank;
  logic [12:0] b_row;
  logic [9:0]  b_col;
  logic [2:0]  b_cnt;
  logic        b_ap;
  logic        v0, v1;
  logic [DATA_WIDTH-1:0] rd_q, d1;
  logic [DATA_WIDTH-1:0] mem [2**MEM_ADDR_WIDTH];

  logic c_nop, c_act, c_rd, c_wr;
  logic c_pre, c_ref, c_lmr, c_bst;
  logic new_rd, new_wr, new_cmd;
  logic cont, intr, last, busy;
  logic iss_rd, iss_wr, beat;
  logic [2:0] mask, lo;
  logic [MEM_ADDR_WIDTH-1:0] idx;

  always_comb begin
    c_nop = 1'b0; c_act = 1'b0;
    c_rd  = 1'b0; c_wr  = 1'b0;
    c_pre = 1'b0; c_ref = 1'b0;
    c_lmr = 1'b0; c_bst = 1'b0;
    unique case ({bus.ras_n, bus.cas_n, bus.we_n})
      3'b111: c_nop = 1'b1;
      3'b011: c_act = 1'b1;
      3'b101: c_rd  = 1'b1;
      3'b100: c_wr  = 1'b1;
      3'b010: c_pre = 1'b1;
      3'b001: c_ref = 1'b1;
      3'b000: c_lmr = 1'b1;
      3'b110: c_bst = 1'b1;
      default: c_nop = 1'b1;
    endcase
  end

  always_comb begin
    mask    = 3'(bl_q - 4'd1);
    new_rd  = c_rd & open_q[bus.ba];
    new_wr  = c_wr & open_q[bus.ba];
    new_cmd = new_rd | new_wr;
    cont    = (st != S_IDLE) & ~c_bst & ~new_cmd;
    intr    = (st != S_IDLE) & (c_bst | new_cmd);
    last    = (b_cnt == mask);
    iss_rd  = new_rd | (cont & (st == S_RD));
    iss_wr  = new_wr | (cont & (st == S_WR));
    busy    = (st != S_IDLE) | v0 | v1;
    // Column bits above log2(BL) stay fixed; low bits wrap.
    lo = (b_col[2:0] & ~mask)
       | ((b_col[2:0] + b_cnt) & mask);
    idx = new_cmd
      ? MEM_ADDR_WIDTH'({bus.ba, row_q[bus.ba],
                         bus.addr[9:0]})
      : MEM_ADDR_WIDTH'({b_bank, b_row,
                         b_col[9:3], lo});
    // Banks to close on the next edge: finished or cut-off
    // burst with auto precharge, or a single-beat one.
    ap_nxt = 4'b0000;
    if (b_ap & ((cont & last) | intr))
      ap_nxt[b_bank] = 1'b1;
    if (new_cmd & bus.addr[10] & (bl_q == 4'd1))
      ap_nxt[bus.ba] = 1'b1;
    st_nxt = st;
    if (new_rd)
      st_nxt = (bl_q == 4'd1) ? S_IDLE : S_RD;
    else if (new_wr)
      st_nxt = (bl_q == 4'd1) ? S_IDLE : S_WR;
    else if (c_bst | (cont & last))
      st_nxt = S_IDLE;
    beat = cl3_q ? v1 : v0;
  end

  always_ff @(posedge clk) begin
    if (rst) st <= S_IDLE;
    else     st <= st_nxt;
  end

  always_ff @(posedge clk) begin
    if (iss_wr & ~rst)
      mem[idx] <= bus.dq_in;
    rd_q <= mem[idx];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      open_q            <= 4'b0000;
      ap_q              <= 4'b0000;
      for (int i = 0; i < 4; i++)
        row_q[i]        <= '0;
      cl3_q             <= 1'b0;
      bl_q              <= 4'd1;
      b_bank            <= '0;
      b_row             <= '0;
      b_col             <= '0;
      b_cnt             <= '0;
      b_ap              <= 1'b0;
      v0                <= 1'b0;
      v1                <= 1'b0;
      d1                <= '0;
      bus.dq_out        <= '0;
      bus.dq_oe         <= 1'b0;
      bus.cmd_err       <= 1'b0;
      bus.refresh_count <= '0;
    end else begin
      ap_q   <= ap_nxt;
      open_q <= open_q & ~ap_q;
      unique case (1'b1)
        c_act: begin
          if (open_q[bus.ba]) begin
            bus.cmd_err <= 1'b1;
          end else begin
            open_q[bus.ba] <= 1'b1;
            row_q[bus.ba]  <= bus.addr;
          end
        end
        c_pre: begin
          if (bus.addr[10]) open_q <= 4'b0000;
          else              open_q[bus.ba] <= 1'b0;
        end
        c_ref: begin
          if (|open_q) bus.cmd_err <= 1'b1;
          else bus.refresh_count <= bus.refresh_count + 16'd1;
        end
        c_lmr: begin
          if ((|open_q) | busy) begin
            bus.cmd_err <= 1'b1;
          end else begin
            if (bus.addr[6:4] == 3'd2)      cl3_q <= 1'b0;
            else if (bus.addr[6:4] == 3'd3) cl3_q <= 1'b1;
            else                            bus.cmd_err <= 1'b1;
            if (!bus.addr[2])
              bl_q <= 4'd1 << bus.addr[1:0];
            else
              bus.cmd_err <= 1'b1;
          end
        end
        c_rd, c_wr: begin
          if (!open_q[bus.ba]) bus.cmd_err <= 1'b1;
        end
        default: ;
      endcase
      if (new_cmd) begin
        b_bank <= bus.ba;
        b_row  <= row_q[bus.ba];
        b_col  <= bus.addr[9:0];
        b_cnt  <= 3'd1;
        b_ap   <= bus.addr[10];
      end else if (cont) begin
        b_cnt  <= b_cnt + 3'd1;
      end
      // A write flushes every pending read beat.
      v0        <= iss_rd;
      v1        <= v0 & ~new_wr;
      d1        <= rd_q;
      bus.dq_oe <= beat & ~new_wr;
      if (beat)
        bus.dq_out <= cl3_q ? d1 : rd_q;
    end
  end
endmodule

// File: tb/tb_sdram_cmd_responder.sv
// Directed bench for sdram_cmd_responder: vector table plus
// hand sequences for interrupts, errors, refresh wrap, reset.
module tb_sdram_cmd_responder;
  localparam logic [2:0] NOP = 3'b111;
  localparam logic [2:0] ACT = 3'b011;
  localparam logic [2:0] RD  = 3'b101;
  localparam logic [2:0] WR  = 3'b100;
  localparam logic [2:0] PRE = 3'b010;
  localparam logic [2:0] REF = 3'b001;
  localparam logic [2:0] LMR = 3'b000;

  typedef struct {
    logic [2:0]  c;
    logic [1:0]  b;
    logic [12:0] a;
    logic [15:0] d;
    logic        oe;
    logic [15:0] q;
    logic        err;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int failures = 0;
  vec_t tbl[$];

  always #5 clk = ~clk;

  sdram_cmd_responder_if #(.DATA_WIDTH(16)) bus();

  sdram_cmd_responder #(
    .MEM_ADDR_WIDTH(12),
    .DATA_WIDTH(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h",
               nm, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0]  c,
                       input logic [1:0]  b,
                       input logic [12:0] a,
                       input logic [15:0] d);
    {bus.ras_n, bus.cas_n, bus.we_n} = c;
    bus.ba    = b;
    bus.addr  = a;
    bus.dq_in = d;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(NOP, 2'd0, 13'h0, 16'h0);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    {bus.ras_n, bus.cas_n, bus.we_n} = NOP;
    bus.ba = 2'd0;
    bus.addr = 13'h0;
    bus.dq_in = 16'h0;
    drive(NOP, 2'd0, 13'h0, 16'h0);
    rst = 1'b0;
    // Preload mem[31]; memory survives the following reset.
    drive(ACT, 2'd0, 13'h000, 16'h0);
    drive(WR,  2'd0, 13'h01F, 16'h6002);
    drive(NOP, 2'd0, 13'h000, 16'h0);
    do_reset();
    chk("rst_oe",  32'(bus.dq_oe), 32'd0);
    chk("rst_out", 32'(bus.dq_out), 32'd0);
    chk("rst_err", 32'(bus.cmd_err), 32'd0);
    chk("rst_rc",  32'(bus.refresh_count), 32'd0);

    tbl.push_back('{ACT, 2'd0, 13'h000, 16'h0,    1'b0, 16'h0,    1'b0});
    tbl.push_back('{RD,  2'd0, 13'h01F, 16'h0,    1'b0, 16'h0,    1'b0});
    tbl.push_back('{NOP, 2'd0, 13'h000, 16'h0,    1'b1, 16'h6002, 1'b0});
    tbl.push_back('{NOP, 2'd0, 13'h000, 16'h0,    1'b0, 16'h0,    1'b0});
    tbl.push_back('{PRE, 2'd0, 13'h400, 16'h0,    1'b0, 16'h0,    1'b0});
    tbl.push_back('{LMR, 2'd0, 13'h032, 16'h0,    1'b0, 16'h0,    1'b0});
    tbl.push_back('{ACT, 2'd0, 13'h005, 16'h0,    1'b0, 16'h0,    1'b0});
    tbl.push_back('{WR,  2'd0, 13'h002, 16'hA1A1, 1'b0, 16'h0,    1'b0});
    tbl.push_back('{NOP, 2'd0, 13'h000, 16'hB2B2, 1'b0, 16'h0,    1'b0});
    tbl.push_back('{NOP, 2'd0, 13'h000, 16'hC3C3, 1'b0, 16'h0,    1'b0});
    tbl.push_back('{NOP, 2'd0, 13'h000, 16'hD4D4, 1'b0, 16'h0,    1'b0});
    tbl.push_back('{RD,  2'd0, 13'h000, 16'h0,    1'b0, 16'h0,    1'b0});
    tbl.push_back('{NOP, 2'd0, 13'h000, 16'h0,    1'b0, 16'h0,    1'b0});
    tbl.push_back('{NOP, 2'd0, 13'h000, 16'h0,    1'b1, 16'hC3C3, 1'b0});
    tbl.push_back('{NOP, 2'd0, 13'h000, 16'h0,    1'b1, 16'hD4D4, 1'b0});
    tbl.push_back('{NOP, 2'd0, 13'h000, 16'h0,    1'b1, 16'hA1A1, 1'b0});
    tbl.push_back('{NOP, 2'd0, 13'h000, 16'h0,    1'b1, 16'hB2B2, 1'b0});
    tbl.push_back('{NOP, 2'd0, 13'h000, 16'h0,    1'b0, 16'h0,    1'b0});

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].c, tbl[i].b, tbl[i].a, tbl[i].d);
      chk($sformatf("vec%0d_oe", i),
          32'(bus.dq_oe), 32'(tbl[i].oe));
      if (tbl[i].oe)
        chk($sformatf("vec%0d_out", i),
            32'(bus.dq_out), 32'(tbl[i].q));
      chk($sformatf("vec%0d_err", i),
          32'(bus.cmd_err), 32'(tbl[i].err));
    end

    // CL=3 BL=8 read cut off by a write two cycles later.
    drive(PRE, 2'd0, 13'h400, 16'h0);
    drive(LMR, 2'd0, 13'h033, 16'h0);
    drive(ACT, 2'd1, 13'h007, 16'h0);
    drive(RD,  2'd1, 13'h000, 16'h0);
    drive(NOP, 2'd1, 13'h000, 16'h0);
    drive(WR,  2'd1, 13'h005, 16'h5A5A);
    chk("intr_oe_w", 32'(bus.dq_oe), 32'd0);
    for (int k = 1; k < 8; k++) begin
      drive(NOP, 2'd1, 13'h000, 16'(k));
      chk($sformatf("intr_oe_w%0d", k),
          32'(bus.dq_oe), 32'd0);
    end
    drive(RD,  2'd1, 13'h005, 16'h0);
    drive(NOP, 2'd1, 13'h000, 16'h0);
    for (int i = 0; i < 8; i++) begin
      drive(NOP, 2'd1, 13'h000, 16'h0);
      chk($sformatf("rb_oe%0d", i),
          32'(bus.dq_oe), 32'd1);
      chk($sformatf("rb_out%0d", i), 32'(bus.dq_out),
          (i == 0) ? 32'h5A5A : 32'(i));
    end
    drive(NOP, 2'd1, 13'h000, 16'h0);
    chk("rb_oe_end", 32'(bus.dq_oe), 32'd0);
    chk("rb_err", 32'(bus.cmd_err), 32'd0);

    // Protocol errors.
    do_reset();
    drive(RD, 2'd1, 13'h000, 16'h0);
    chk("closed_rd_err", 32'(bus.cmd_err), 32'd1);
    for (int i = 0; i < 3; i++) begin
      drive(NOP, 2'd0, 13'h000, 16'h0);
      chk($sformatf("closed_rd_oe%0d", i),
          32'(bus.dq_oe), 32'd0);
    end
    do_reset();
    chk("err_cleared", 32'(bus.cmd_err), 32'd0);
    drive(ACT, 2'd2, 13'h011, 16'h0);
    chk("act1_err", 32'(bus.cmd_err), 32'd0);
    drive(ACT, 2'd2, 13'h022, 16'h0);
    chk("act2_err", 32'(bus.cmd_err), 32'd1);
    do_reset();
    drive(ACT, 2'd0, 13'h000, 16'h0);
    drive(REF, 2'd0, 13'h000, 16'h0);
    chk("ref_open_err", 32'(bus.cmd_err), 32'd1);
    chk("ref_open_rc", 32'(bus.refresh_count), 32'd0);

    // Auto precharge, then refresh and wrap.
    do_reset();
    drive(ACT, 2'd0, 13'h000, 16'h0);
    drive(RD,  2'd0, 13'h41F, 16'h0);
    drive(NOP, 2'd0, 13'h000, 16'h0);
    chk("ap_oe",  32'(bus.dq_oe), 32'd1);
    chk("ap_out", 32'(bus.dq_out), 32'h6002);
    drive(NOP, 2'd0, 13'h000, 16'h0);
    drive(REF, 2'd0, 13'h000, 16'h0);
    chk("ap_ref_rc",  32'(bus.refresh_count), 32'd1);
    chk("ap_ref_err", 32'(bus.cmd_err), 32'd0);
    for (int i = 0; i < 65534; i++)
      drive(REF, 2'd0, 13'h000, 16'h0);
    chk("rc_max", 32'(bus.refresh_count), 32'hFFFF);
    drive(REF, 2'd0, 13'h000, 16'h0);
    chk("rc_wrap", 32'(bus.refresh_count), 32'd0);
    chk("rc_err", 32'(bus.cmd_err), 32'd0);

    // Reset in the middle of a CL=2 BL=8 read.
    do_reset();
    drive(LMR, 2'd0, 13'h023, 16'h0);
    drive(ACT, 2'd0, 13'h000, 16'h0);
    drive(RD,  2'd0, 13'h018, 16'h0);
    drive(NOP, 2'd0, 13'h000, 16'h0);
    chk("mid_oe1", 32'(bus.dq_oe), 32'd1);
    drive(NOP, 2'd0, 13'h000, 16'h0);
    chk("mid_oe2", 32'(bus.dq_oe), 32'd1);
    rst = 1'b1;
    drive(NOP, 2'd0, 13'h000, 16'h0);
    chk("mid_rst_oe",  32'(bus.dq_oe), 32'd0);
    chk("mid_rst_out", 32'(bus.dq_out), 32'd0);
    rst = 1'b0;
    drive(RD, 2'd0, 13'h000, 16'h0);
    chk("mid_rd_err", 32'(bus.cmd_err), 32'd1);
    for (int i = 0; i < 3; i++) begin
      drive(NOP, 2'd0, 13'h000, 16'h0);
      chk($sformatf("mid_rd_oe%0d", i),
          32'(bus.dq_oe), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end
endmodule
